// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Five-stage pipeline control: memory stalls, mispredict flush,
//               load-use bubble insertion and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [6:0]  ex_opcode,
  input  logic [4:0]  ex_rd,
  input  logic        br_taken_ex,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  output logic        load_pc,
  output logic        load_ifid,
  output logic        load_idex,
  output logic        load_exmem,
  output logic        load_memwb,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        pc_sel,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_count,
  output logic [31:0] flush_count
);

  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_i_done;
  logic        r_d_done;
  logic        w_i_done_nxt;
  logic        w_d_done_nxt;
  logic [31:0] r_stall_cycles;
  logic [31:0] r_bubble_count;
  logic [31:0] r_flush_count;

  logic w_i_ok;
  logic w_d_ok;
  logic w_advance;
  logic w_rs1_used;
  logic w_rs2_used;
  logic w_hazard;
  logic w_inc_stall;
  logic w_inc_bubble;
  logic w_inc_flush;

  // A fetch/data response counts if it arrives now or was banked while waiting.
  assign w_i_ok    = imem_resp | r_i_done;
  assign w_d_ok    = !dmem_req | dmem_resp | r_d_done;
  assign w_advance = w_i_ok & w_d_ok;

  always_comb begin
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (id_opcode)
      c_OP_JALR, c_OP_LOAD, c_OP_IMM: w_rs1_used = 1'b1;
      c_OP_BRANCH, c_OP_STORE, c_OP_REG: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_hazard = (ex_opcode == c_OP_LOAD) && (ex_rd != 5'd0) &&
                    ((w_rs1_used && (id_rs1 == ex_rd)) ||
                     (w_rs2_used && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_i_done       <= 1'b0;
      r_d_done       <= 1'b0;
      r_stall_cycles <= 32'd0;
      r_bubble_count <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_i_done       <= w_i_done_nxt;
      r_d_done       <= w_d_done_nxt;
      if (w_inc_stall)  r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_inc_bubble) r_bubble_count <= r_bubble_count + 32'd1;
      if (w_inc_flush)  r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_i_done_nxt = r_i_done;
    w_d_done_nxt = r_d_done;
    load_pc      = 1'b0;
    load_ifid    = 1'b0;
    load_idex    = 1'b0;
    load_exmem   = 1'b0;
    load_memwb   = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    pc_sel       = 1'b0;
    w_inc_stall  = 1'b0;
    w_inc_bubble = 1'b0;
    w_inc_flush  = 1'b0;

    if (!rst) begin
      if (!w_advance) begin
        // Done bits are zero in RUN, so OR-ing covers both RUN->WAIT and WAIT.
        w_state_nxt  = ST_WAIT;
        w_i_done_nxt = r_i_done | imem_resp;
        w_d_done_nxt = r_d_done | (dmem_req & dmem_resp);
        w_inc_stall  = 1'b1;
      end else begin
        w_state_nxt  = ST_RUN;
        w_i_done_nxt = 1'b0;
        w_d_done_nxt = 1'b0;
        load_exmem   = 1'b1;
        load_memwb   = 1'b1;
        load_idex    = 1'b1;
        if (br_taken_ex) begin
          // Mispredict wins: the hazarding ID instruction is squashed anyway.
          load_pc     = 1'b1;
          load_ifid   = 1'b1;
          pc_sel      = 1'b1;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          w_inc_flush = 1'b1;
        end else if (w_hazard) begin
          flush_idex   = 1'b1;
          w_inc_bubble = 1'b1;
        end else begin
          load_pc   = 1'b1;
          load_ifid = 1'b1;
        end
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign bubble_count = r_bubble_count;
  assign flush_count  = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [6:0]  ex_opcode;
  logic [4:0]  ex_rd;
  logic        br_taken_ex;
  logic        imem_resp;
  logic        dmem_req;
  logic        dmem_resp;
  logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic        flush_ifid, flush_idex, pc_sel;
  logic [31:0] stall_cycles, bubble_count, flush_count;

  int          r_checks = 0;
  int          r_errors = 0;
  logic [31:0] r_exp_stall  = 0;
  logic [31:0] r_exp_bubble = 0;
  logic [31:0] r_exp_flush  = 0;

  // {load_pc, load_ifid, load_idex, load_exmem, load_memwb, flush_ifid, flush_idex, pc_sel}
  localparam logic [7:0] c_STALL = 8'b00000_000;
  localparam logic [7:0] c_ALL   = 8'b11111_000;
  localparam logic [7:0] c_BUB   = 8'b00111_010;
  localparam logic [7:0] c_MISP  = 8'b11111_111;

  wire [7:0] w_ctrl = {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
                       flush_ifid, flush_idex, pc_sel};

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_opcode    (id_opcode),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_opcode    (ex_opcode),
    .ex_rd        (ex_rd),
    .br_taken_ex  (br_taken_ex),
    .imem_resp    (imem_resp),
    .dmem_req     (dmem_req),
    .dmem_resp    (dmem_resp),
    .load_pc      (load_pc),
    .load_ifid    (load_ifid),
    .load_idex    (load_idex),
    .load_exmem   (load_exmem),
    .load_memwb   (load_memwb),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .pc_sel       (pc_sel),
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count),
    .flush_count  (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are already applied (after a falling edge); check the enables,
  // account the expected counter effect, and move to the next falling edge.
  task automatic step(input string tag, input logic [7:0] exp_ctrl);
    #1;
    check(tag, {24'd0, w_ctrl}, {24'd0, exp_ctrl});
    if (rst) begin
      r_exp_stall  = 0;
      r_exp_bubble = 0;
      r_exp_flush  = 0;
    end else if (exp_ctrl == c_STALL) begin
      r_exp_stall = r_exp_stall + 1;
    end else if (exp_ctrl == c_MISP) begin
      r_exp_flush = r_exp_flush + 1;
    end else if (exp_ctrl == c_BUB) begin
      r_exp_bubble = r_exp_bubble + 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_stall"},  stall_cycles, r_exp_stall);
    check({tag, "_bubble"}, bubble_count, r_exp_bubble);
    check({tag, "_flush"},  flush_count,  r_exp_flush);
  endtask

  task automatic set_mem(input logic im, input logic dq, input logic dr);
    imem_resp = im;
    dmem_req  = dq;
    dmem_resp = dr;
  endtask

  initial begin
    rst = 1'b1;
    id_opcode = 7'b0010011; id_rs1 = 5'd0; id_rs2 = 5'd0;
    ex_opcode = 7'b0010011; ex_rd = 5'd0; br_taken_ex = 1'b0;
    set_mem(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    step("reset_ctrl", c_STALL);
    step("reset_ctrl2", c_STALL);
    rst = 1'b0;
    check_counters("after_reset");

    // Free run
    for (int i = 0; i < 10; i++) step("free_run", c_ALL);
    check_counters("free_run");

    // Split responses: fetch done in cycle 0, data in cycle 3
    set_mem(1'b1, 1'b1, 1'b0); step("split_c0", c_STALL);
    set_mem(1'b0, 1'b1, 1'b0); step("split_c1", c_STALL);
    step("split_c2", c_STALL);
    set_mem(1'b0, 1'b1, 1'b1); step("split_c3", c_ALL);
    check("split_stall3", stall_cycles, 32'd3);
    set_mem(1'b1, 1'b0, 1'b0); step("split_c4_run", c_ALL);
    set_mem(1'b0, 1'b0, 1'b0); step("idone_cleared", c_STALL);

    // Data first, fetch later; data bank held
    set_mem(1'b0, 1'b1, 1'b1); step("dfirst_c0", c_STALL);
    set_mem(1'b0, 1'b1, 1'b0); step("dfirst_c1", c_STALL);
    set_mem(1'b1, 1'b1, 1'b0); step("dfirst_c2", c_ALL);

    // dmem_resp without dmem_req is ignored
    set_mem(1'b0, 1'b0, 1'b1); step("stray_dresp", c_STALL);
    set_mem(1'b1, 1'b1, 1'b0); step("stray_not_banked", c_STALL);
    set_mem(1'b0, 1'b1, 1'b1); step("stray_then_real", c_ALL);
    check_counters("mem_stalls");

    // Load-use hazard
    set_mem(1'b1, 1'b0, 1'b0);
    ex_opcode = 7'b0000011; ex_rd = 5'd5;
    id_opcode = 7'b0110011; id_rs1 = 5'd1; id_rs2 = 5'd5;
    step("lu_rs2", c_BUB);
    check("lu_bubble1", bubble_count, 32'd1);
    ex_rd = 5'd0; id_rs2 = 5'd0; step("lu_rd0", c_ALL);
    ex_rd = 5'd5; id_opcode = 7'b0010011; id_rs2 = 5'd5; step("lu_imm_rs2_unused", c_ALL);
    id_opcode = 7'b0100011; id_rs1 = 5'd5; id_rs2 = 5'd2; step("lu_store_rs1", c_BUB);
    id_opcode = 7'b0110111; step("lu_lui_none", c_ALL);
    ex_opcode = 7'b0110011; id_opcode = 7'b0100011; step("lu_ex_not_load", c_ALL);
    check_counters("loaduse");

    // Mispredict together with load-use hazard
    ex_opcode = 7'b0000011; ex_rd = 5'd5;
    id_opcode = 7'b0110011; id_rs1 = 5'd1; id_rs2 = 5'd5;
    br_taken_ex = 1'b1;
    step("misp_hazard", c_MISP);
    check("misp_flush1", flush_count, 32'd1);
    check("misp_bubble_unchanged", bubble_count, 32'd2);
    set_mem(1'b0, 1'b0, 1'b0); step("stall_over_misp", c_STALL);
    set_mem(1'b1, 1'b0, 1'b0); step("misp_after_wait", c_MISP);
    br_taken_ex = 1'b0;
    ex_opcode = 7'b0010011; ex_rd = 5'd0;
    check_counters("misp");

    // Reset while waiting: banked fetch and in-reset pulses are dropped
    set_mem(1'b1, 1'b1, 1'b0); step("wait_idone", c_STALL);
    rst = 1'b1;
    set_mem(1'b1, 1'b1, 1'b1); step("rst_in_wait", c_STALL);
    rst = 1'b0;
    check_counters("rst_wait");
    set_mem(1'b0, 1'b1, 1'b1); step("post_rst_dresp", c_STALL);
    set_mem(1'b0, 1'b1, 1'b0); step("post_rst_idle", c_STALL);
    set_mem(1'b1, 1'b1, 1'b0); step("post_rst_imem", c_ALL);
    check_counters("post_rst");

    // Counter wrap
    dut.r_stall_cycles = 32'hFFFF_FFFF;
    r_exp_stall = 32'hFFFF_FFFF;
    set_mem(1'b0, 1'b0, 1'b0); step("wrap_stall", c_STALL);
    check("wrap_zero", stall_cycles, 32'd0);

    $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 id_opcode  input  7  opcode held in IF/ID stage register.
REQ-004 id_rs1, id_rs2  input  5 each  source register indices of ID-stage instruction.
REQ-005 ex_opcode  input  7  opcode held in ID/EX stage register.
REQ-006 ex_rd  input  5  destination register of EX-stage instruction.
REQ-007 br_taken_ex  input  1  EX-stage branch/JAL/JALR resolved taken; level, valid every cycle.
REQ-008 imem_resp  input  1  single-cycle pulse: current instruction fetch completed.
REQ-009 dmem_req  input  1  MEM-stage instruction performs a load/store this cycle.
REQ-010 dmem_resp  input  1  single-cycle pulse: data access completed.
REQ-011 load_pc, load_ifid, load_idex, load_exmem, load_memwb  output  1 each  stage register load enables.
REQ-012 flush_ifid, flush_idex  output  1 each  load NOP (opcode 7'b0010011, all other fields 0) into that stage register instead of its input.
REQ-013 pc_sel  output  1  1 = PC loads EX branch target, 0 = PC+4.
REQ-014 stall_cycles, bubble_count, flush_count  output  32 each  performance counters.

Function
REQ-015 States SHALL be RUN and WAIT; registered bits i_done, d_done track responses received while in WAIT.
REQ-016 Per cycle: i_ok = imem_resp | i_done; d_ok = !dmem_req | dmem_resp | d_done; advance = i_ok & d_ok.
REQ-017 When !advance, all load_* and flush_* SHALL be 0, pc_sel 0, and stall_cycles SHALL increment.
REQ-018 RUN with !advance SHALL go to WAIT, setting i_done <= imem_resp and d_done <= dmem_req & dmem_resp.
REQ-019 In WAIT, a response pulse SHALL set its done bit; done bits SHALL hold until the advance cycle.
REQ-020 On advance, state SHALL become RUN and i_done, d_done SHALL clear to 0.
REQ-021 Advance with br_taken_ex: all five loads 1, pc_sel 1, flush_ifid 1, flush_idex 1, flush_count +1.
REQ-022 Load-use hazard: ex_opcode == 7'b0000011, ex_rd != 0, and ex_rd matches a used source of the ID instruction.
REQ-023 rs1 is used for opcodes 1100111, 1100011, 0000011, 0100011, 0010011, 0110011; rs2 is used for 1100011, 0100011, 0110011; no other opcode uses either.
REQ-024 Advance with hazard and !br_taken_ex: load_pc 0, load_ifid 0, flush_idex 1, load_exmem 1, load_memwb 1, load_idex 1, bubble_count +1.
REQ-025 Advance with neither condition: all five loads 1, flushes 0, pc_sel 0.
REQ-026 Priority, highest first: memory stall, mispredict, load-use; a mispredict SHALL suppress the load-use bubble and bubble_count.
REQ-027 Counters SHALL wrap 2^32-1 -> 0 silently.
REQ-028 dmem_resp while dmem_req is low, or a second pulse while done is already set, SHALL be ignored.
REQ-029 Outputs other than counters SHALL be a combinational function of the inputs and the registered state; zero-cycle latency from input to enable.

Reset
REQ-030 While rst is high, all load_*, flush_* and pc_sel SHALL be 0 and no counter SHALL increment.
REQ-031 On the edge with rst high: state <= RUN, i_done <= 0, d_done <= 0, all counters <= 0.
REQ-032 rst in WAIT SHALL abandon pending responses; a pulse arriving in the rst cycle SHALL not be recorded.

Verification
REQ-033 Free run: imem_resp=1, dmem_req=0, no hazards for 10 cycles -> all loads 1 every cycle, all counters 0.
REQ-034 Split responses: dmem_req=1, imem_resp in cycle 0, dmem_resp in cycle 3 -> loads 0 in cycles 0-2, all loads 1 in cycle 3, stall_cycles=3, state RUN in cycle 4.
REQ-035 Load-use: ex_opcode=0000011, ex_rd=5, id_opcode=0110011, id_rs2=5 -> load_pc=0, load_ifid=0, flush_idex=1, bubble_count=1. With ex_rd=0 -> no bubble.
REQ-036 Mispredict and load-use together: br_taken_ex=1 plus the REQ-035 hazard -> pc_sel=1, both flushes 1, flush_count=1, bubble_count=0.
REQ-037 Reset in WAIT: i_done set, rst for 1 cycle, then dmem_resp only -> no advance until a new imem_resp; counters read 0 after rst.
REQ-038 Wrap: preload stall_cycles to 32'hFFFFFFFF, stall 1 cycle -> 0.
